// File: rtl/reg_write_buffer_if.sv
// Writeback request channels (ALU "a", memory "b") and the register-file write port.
// The slave side is the buffer; the master side drives requests and the hold.
interface reg_write_buffer_if #(
  parameter int XLEN = 64
);
  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;

  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;

  logic            wb_hold;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  wb_hold,
    output a_ready, b_ready,
    output wb_en, wb_addr, wb_data
  );

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output wb_hold,
    input  a_ready, b_ready,
    input  wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/reg_write_buffer.sv
// In-order writeback FIFO between the EX/MEM result paths and the register file,
// with per-register busy bits and newest-value forwarding for two read addresses.
module reg_write_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  reg_write_buffer_if.slave            bus,
  input  logic [4:0]                   qry_rs1,
  input  logic [4:0]                   qry_rs2,
  output logic                         fwd1_hit,
  output logic [XLEN-1:0]              fwd1_data,
  output logic                         fwd2_hit,
  output logic [XLEN-1:0]              fwd2_data,
  output logic [31:0]                  busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t             r_head;
  ptr_t             r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_valid;
  logic [4:0]       r_rd   [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];

  logic [CNT_W-1:0] w_free;
  logic             w_b_push;
  logic             w_a_push;
  logic             w_pop;
  ptr_t             w_a_idx;
  logic [DEPTH-1:0] w_wr_b;
  logic [DEPTH-1:0] w_wr_a;
  logic [DEPTH-1:0] w_clr;
  ptr_t             w_age_idx [DEPTH];

  // Readiness looks only at the registered count, so a drain in the same
  // cycle never frees a slot for an incoming request.
  assign w_free      = CNT_W'(DEPTH) - r_count;
  assign count       = r_count;
  assign full        = (r_count == CNT_W'(DEPTH));
  assign empty       = (r_count == '0);
  assign bus.b_ready = (w_free >= CNT_W'(1));
  assign bus.a_ready = bus.b_valid ? (w_free >= CNT_W'(2)) : (w_free >= CNT_W'(1));

  // x0 requests complete the handshake but never occupy a slot.
  assign w_b_push = bus.b_valid & bus.b_ready & (bus.b_rd != 5'd0);
  assign w_a_push = bus.a_valid & bus.a_ready & (bus.a_rd != 5'd0);
  assign w_a_idx  = r_tail + ptr_t'(w_b_push);

  assign w_pop       = !empty & !bus.wb_hold;
  assign bus.wb_en   = w_pop;
  assign bus.wb_addr = w_pop ? r_rd[r_head]   : 5'd0;
  assign bus.wb_data = w_pop ? r_data[r_head] : '0;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_wr_b[gi]    = w_b_push && (r_tail  == ptr_t'(gi));
      assign w_wr_a[gi]    = w_a_push && (w_a_idx == ptr_t'(gi));
      assign w_clr[gi]     = w_pop    && (r_head  == ptr_t'(gi));
      assign w_age_idx[gi] = r_head + ptr_t'(gi);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_head  <= r_head + ptr_t'(w_pop);
      r_tail  <= r_tail + ptr_t'(w_a_push) + ptr_t'(w_b_push);
      r_count <= r_count + CNT_W'(w_a_push) + CNT_W'(w_b_push) - CNT_W'(w_pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_b[i] | w_wr_a[i]) begin
          r_valid[i] <= 1'b1;
        end else if (w_clr[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Payload storage needs no reset: it is only observed through valid slots.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_b[i]) begin
        r_rd[i]   <= bus.b_rd;
        r_data[i] <= bus.b_data;
      end else if (w_wr_a[i]) begin
        r_rd[i]   <= bus.a_rd;
        r_data[i] <= bus.a_data;
      end
    end
  end

  // Scan oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    busy      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[w_age_idx[i]]) begin
        if ((qry_rs1 != 5'd0) && (r_rd[w_age_idx[i]] == qry_rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = r_data[w_age_idx[i]];
        end
        if ((qry_rs2 != 5'd0) && (r_rd[w_age_idx[i]] == qry_rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = r_data[w_age_idx[i]];
        end
      end
      if (r_valid[i]) begin
        busy[r_rd[i]] = 1'b1;
      end
    end
    busy[0] = 1'b0;
  end

endmodule
